// File: rtl/sccb_responder.sv
// sccb_responder: SCCB peripheral decoding 3-phase writes, 2-phase writes and 2-phase reads.
// SCL/SDA are oversampled on clk; SDA is only ever pulled low or released.
module sccb_responder #(
   parameter logic [6:0]  DEVICE_ID   = 7'h21,
   parameter bit          DRIVE_ACK   = 1'b1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_scl,
   inout  wire        io_sda,
   output logic       o_wr_en,
   output logic [7:0] o_wr_addr,
   output logic [7:0] o_wr_data,
   output logic [7:0] o_rd_addr,
   input  logic [7:0] i_rd_data,
   output logic       o_busy,
   output logic       o_start_det,
   output logic       o_stop_det,
   output logic [3:0] o_state
);

   typedef enum logic [3:0] {
      StIdle     = 4'd0,
      StIdByte   = 4'd1,
      StIdX      = 4'd2,
      StSubByte  = 4'd3,
      StSubX     = 4'd4,
      StDataByte = 4'd5,
      StDataX    = 4'd6,
      StRdByte   = 4'd7,
      StRdX      = 4'd8,
      StIgnore   = 4'd9
   } state_e;

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl, sda, scl_q, sda_q;
   logic                   scl_rise, scl_fall, start_ev, stop_ev;
   state_e                 state;
   logic [2:0]             bit_cnt;
   logic                   last_bit;
   logic [7:0]             shift, shift_nxt, rd_data_q;
   logic                   sda_oe;

   // Sync flops idle high so leaving reset on an idle bus raises no events.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], io_sda};
         scl_q    <= scl;
         sda_q    <= sda;
      end
   end

   assign scl       = scl_sync[SYNC_STAGES-1];
   assign sda       = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl & ~scl_q;
   assign scl_fall  = ~scl & scl_q;
   assign start_ev  = ~sda & sda_q & scl;
   assign stop_ev   = sda & ~sda_q & scl;
   assign shift_nxt = {shift[6:0], sda};
   assign io_sda    = sda_oe ? 1'b0 : 1'bz;
   assign o_state   = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= StIdle;
         bit_cnt     <= 3'd7;
         last_bit    <= 1'b0;
         shift       <= 8'h00;
         rd_data_q   <= 8'h00;
         sda_oe      <= 1'b0;
         o_wr_en     <= 1'b0;
         o_wr_addr   <= 8'h00;
         o_wr_data   <= 8'h00;
         o_rd_addr   <= 8'h00;
         o_busy      <= 1'b0;
         o_start_det <= 1'b0;
         o_stop_det  <= 1'b0;
      end else begin
         o_start_det <= start_ev;
         o_stop_det  <= stop_ev;
         o_wr_en     <= 1'b0;
         rd_data_q   <= i_rd_data;
         if (start_ev) begin
            state    <= StIdByte;
            bit_cnt  <= 3'd7;
            last_bit <= 1'b0;
            sda_oe   <= 1'b0;
            o_busy   <= 1'b0;
         end else if (stop_ev) begin
            state  <= StIdle;
            sda_oe <= 1'b0;
            o_busy <= 1'b0;
         end else begin
            unique case (state)
               StIdByte, StSubByte, StDataByte: begin
                  if (scl_rise && !last_bit) begin
                     shift <= shift_nxt;
                     if (bit_cnt == 3'd0) begin
                        last_bit <= 1'b1;
                        if (state == StSubByte) o_rd_addr <= shift_nxt;
                        if (state == StDataByte) begin
                           o_wr_en   <= 1'b1;
                           o_wr_addr <= o_rd_addr;
                           o_wr_data <= shift_nxt;
                        end
                     end else begin
                        bit_cnt <= bit_cnt - 3'd1;
                     end
                  end else if (scl_fall && last_bit) begin
                     // The falling edge after bit 0 opens the X bit.
                     last_bit <= 1'b0;
                     if (state == StIdByte && shift[7:1] != DEVICE_ID) begin
                        state <= StIgnore;
                     end else begin
                        state  <= (state == StIdByte)  ? StIdX  :
                                  (state == StSubByte) ? StSubX : StDataX;
                        sda_oe <= DRIVE_ACK;
                        o_busy <= 1'b1;
                     end
                  end
               end
               StIdX: begin
                  if (scl_fall) begin
                     bit_cnt <= 3'd7;
                     if (shift[0]) begin
                        state  <= StRdByte;
                        shift  <= rd_data_q;
                        sda_oe <= ~rd_data_q[7];
                     end else begin
                        state  <= StSubByte;
                        sda_oe <= 1'b0;
                     end
                  end
               end
               StSubX: begin
                  if (scl_fall) begin
                     state   <= StDataByte;
                     bit_cnt <= 3'd7;
                     sda_oe  <= 1'b0;
                  end
               end
               StDataX: begin
                  if (scl_fall) begin
                     state  <= StIgnore;
                     sda_oe <= 1'b0;
                  end
               end
               StRdByte: begin
                  if (scl_fall) begin
                     if (bit_cnt == 3'd0) begin
                        state  <= StRdX;
                        sda_oe <= 1'b0;
                     end else begin
                        bit_cnt <= bit_cnt - 3'd1;
                        shift   <= {shift[6:0], 1'b0};
                        sda_oe  <= ~shift[6];
                     end
                  end
               end
               StRdX: begin
                  sda_oe <= 1'b0;
                  if (scl_fall) state <= StIgnore;
               end
               StIdle, StIgnore: begin
                  sda_oe <= 1'b0;
               end
               default: begin
                  state  <= StIdle;
                  sda_oe <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sccb_responder.sv
`timescale 1ns/1ps
// Bench for sccb_responder: bit-banged SCCB initiator, a vector table, directed corner
// sequences and randomized transactions scored against a transaction-level model.
module tb_sccb_responder;

   localparam int Q = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       m_scl = 1'b1;
   logic       m_sda_low = 1'b0;
   wire        sda;
   logic       o_wr_en, o_busy, o_start_det, o_stop_det;
   logic [7:0] o_wr_addr, o_wr_data, o_rd_addr, i_rd_data;
   logic [3:0] o_state;
   logic [7:0] rf [256];

   assign sda = m_sda_low ? 1'b0 : 1'bz;
   pullup (sda);

   always #5 clk = ~clk;

   sccb_responder #(
      .DEVICE_ID   (7'h21),
      .DRIVE_ACK   (1'b1),
      .SYNC_STAGES (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_scl       (m_scl),
      .io_sda      (sda),
      .o_wr_en     (o_wr_en),
      .o_wr_addr   (o_wr_addr),
      .o_wr_data   (o_wr_data),
      .o_rd_addr   (o_rd_addr),
      .i_rd_data   (i_rd_data),
      .o_busy      (o_busy),
      .o_start_det (o_start_det),
      .o_stop_det  (o_stop_det),
      .o_state     (o_state)
   );

   // External register file served by the responder.
   assign i_rd_data = rf[o_rd_addr];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) rf[i] <= 8'(i) ^ 8'h7C;
      end else if (o_wr_en) begin
         rf[o_wr_addr] <= o_wr_data;
      end
   end

   int         wr_pulses = 0, start_pulses = 0, stop_pulses = 0, dut_low = 0;
   logic [7:0] mon_waddr = 8'h00, mon_wdata = 8'h00;
   always @(negedge clk) begin
      if (o_wr_en) begin
         wr_pulses <= wr_pulses + 1;
         mon_waddr <= o_wr_addr;
         mon_wdata <= o_wr_data;
      end
      if (o_start_det) start_pulses <= start_pulses + 1;
      if (o_stop_det) stop_pulses <= stop_pulses + 1;
      if (sda == 1'b0 && !m_sda_low) dut_low <= dut_low + 1;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_cond();
      m_sda_low = 1'b0; tick(Q);
      m_scl = 1'b1;     tick(Q);
      m_sda_low = 1'b1; tick(Q);
      m_scl = 1'b0;     tick(Q);
   endtask

   task automatic stop_cond();
      m_sda_low = 1'b1; tick(Q);
      m_scl = 1'b1;     tick(Q);
      m_sda_low = 1'b0; tick(2 * Q);
   endtask

   task automatic send_bit(input logic b, output logic rb);
      m_sda_low = ~b; tick(Q);
      m_scl = 1'b1;   tick(Q);
      rb = sda;       tick(Q);
      m_scl = 1'b0;   tick(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic acked);
      logic rb;
      for (int i = 7; i >= 0; i--) send_bit(b[i], rb);
      send_bit(1'b1, rb);
      acked = ~rb;
   endtask

   task automatic recv_byte(output logic [7:0] d);
      logic rb;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, rb);
         d[i] = rb;
      end
      send_bit(1'b1, rb);
   endtask

   task automatic txn(input logic [7:0] id, input logic [7:0] sub, input logic [7:0] dat,
                      input int nwr, output logic [3:0] acks, output logic [7:0] rdata,
                      output logic busy_mid);
      logic a;
      acks  = 4'b0000;
      rdata = 8'hFF;
      start_cond();
      send_byte(id, a);
      acks[0]  = a;
      busy_mid = o_busy;
      if (id[0]) begin
         recv_byte(rdata);
      end else begin
         if (nwr >= 1) begin send_byte(sub, a);  acks[1] = a; end
         if (nwr >= 2) begin send_byte(dat, a);  acks[2] = a; end
         if (nwr >= 3) begin send_byte(~dat, a); acks[3] = a; end
      end
      stop_cond();
   endtask

   task automatic run_check(input string tag, input logic [7:0] id, input logic [7:0] sub,
                            input logic [7:0] dat, input int nwr, input logic [3:0] e_acks,
                            input int e_wr, input logic [7:0] e_waddr, input logic [7:0] e_wdata,
                            input logic [7:0] e_rdata, input logic [7:0] e_rd_addr,
                            input logic e_busy);
      int         b_wr, b_st, b_sp, b_low;
      logic [3:0] acks;
      logic [7:0] rdata;
      logic       busy_mid;
      b_wr  = wr_pulses;
      b_st  = start_pulses;
      b_sp  = stop_pulses;
      b_low = dut_low;
      txn(id, sub, dat, nwr, acks, rdata, busy_mid);
      check({tag, ".acks"}, acks, e_acks);
      check({tag, ".wr_pulses"}, wr_pulses - b_wr, e_wr);
      if (e_wr != 0) begin
         check({tag, ".wr_addr"}, mon_waddr, e_waddr);
         check({tag, ".wr_data"}, mon_wdata, e_wdata);
      end
      if (id[0]) check({tag, ".rdata"}, rdata, e_rdata);
      check({tag, ".rd_addr"}, o_rd_addr, e_rd_addr);
      check({tag, ".busy_mid"}, busy_mid, e_busy);
      check({tag, ".busy_end"}, o_busy, 1'b0);
      check({tag, ".starts"}, start_pulses - b_st, 1);
      check({tag, ".stops"}, stop_pulses - b_sp, 1);
      if (!e_busy) check({tag, ".never_driven"}, dut_low - b_low, 0);
   endtask

   typedef struct {
      string      name;
      logic [7:0] id, sub, dat;
      int         nwr;
      logic [3:0] acks;
      int         wr;
      logic [7:0] waddr, wdata, rdata, rd_addr;
      logic       busy;
   } vec_t;

   vec_t       vt [8];
   logic [7:0] mregs [256];
   logic [7:0] m_rd_addr;

   initial begin
      logic       a, busy_mid;
      logic [7:0] d;
      int         b_wr, b_st, b_sp;

      vt[0] = '{"w3",    8'h42, 8'h12, 8'h80, 2, 4'b0111, 1, 8'h12, 8'h80, 8'h00, 8'h12, 1'b1};
      vt[1] = '{"w2",    8'h42, 8'h0A, 8'h00, 1, 4'b0011, 0, 8'h00, 8'h00, 8'h00, 8'h0A, 1'b1};
      vt[2] = '{"rd",    8'h43, 8'h00, 8'h00, 0, 4'b0001, 0, 8'h00, 8'h00, 8'h76, 8'h0A, 1'b1};
      vt[3] = '{"badid", 8'h60, 8'h12, 8'h34, 2, 4'b0000, 0, 8'h00, 8'h00, 8'h00, 8'h0A, 1'b0};
      vt[4] = '{"w3x",   8'h42, 8'h33, 8'hAB, 3, 4'b0111, 1, 8'h33, 8'hAB, 8'h00, 8'h33, 1'b1};
      vt[5] = '{"rd2",   8'h43, 8'h00, 8'h00, 0, 4'b0001, 0, 8'h00, 8'h00, 8'hAB, 8'h33, 1'b1};
      vt[6] = '{"badrd", 8'h61, 8'h00, 8'h00, 0, 4'b0000, 0, 8'h00, 8'h00, 8'hFF, 8'h33, 1'b0};
      vt[7] = '{"idonly",8'h42, 8'h55, 8'h66, 0, 4'b0001, 0, 8'h00, 8'h00, 8'h00, 8'h33, 1'b1};

      tick(5);
      rst = 1'b0;
      tick(5);
      check("reset.state", o_state, 4'd0);
      check("reset.outs", {o_wr_en, o_busy, o_start_det, o_stop_det}, 4'b0000);
      check("reset.addr_data", {o_wr_addr, o_wr_data, o_rd_addr}, 24'h0);
      check("reset.sda_released", sda, 1'b1);

      for (int i = 0; i < 8; i++)
         run_check(vt[i].name, vt[i].id, vt[i].sub, vt[i].dat, vt[i].nwr, vt[i].acks,
                   vt[i].wr, vt[i].waddr, vt[i].wdata, vt[i].rdata, vt[i].rd_addr, vt[i].busy);

      // STOP after data bit 3 of a 3-phase write.
      b_wr = wr_pulses;
      b_sp = stop_pulses;
      start_cond();
      send_byte(8'h42, a);
      send_byte(8'h12, a);
      for (int i = 7; i >= 3; i--) send_bit(i == 7, a);
      stop_cond();
      check("stopmid.wr_pulses", wr_pulses - b_wr, 0);
      check("stopmid.stops", stop_pulses - b_sp, 1);
      check("stopmid.state", o_state, 4'd0);
      check("stopmid.busy", o_busy, 1'b0);
      check("stopmid.rd_addr", o_rd_addr, 8'h12);

      // Repeated START between the sub-address X bit and a read.
      b_wr = wr_pulses;
      b_st = start_pulses;
      start_cond();
      send_byte(8'h42, a);
      send_byte(8'h44, a);
      start_cond();
      send_byte(8'h43, a);
      check("rstart.ack", a, 1'b1);
      recv_byte(d);
      stop_cond();
      check("rstart.rdata", d, 8'h38);
      check("rstart.starts", start_pulses - b_st, 2);
      check("rstart.wr_pulses", wr_pulses - b_wr, 0);
      check("rstart.rd_addr", o_rd_addr, 8'h44);

      // Reset while the first read bit (a 0) is being driven.
      txn(8'h42, 8'h05, 8'h00, 1, d[3:0], d, busy_mid);
      start_cond();
      send_byte(8'h43, a);
      check("rdrst.driving_low", sda, 1'b0);
      check("rdrst.state_rd", o_state, 4'd7);
      rst = 1'b1;
      tick(1);
      check("rdrst.sda_released", sda, 1'b1);
      check("rdrst.state", o_state, 4'd0);
      check("rdrst.outs", {o_wr_en, o_busy, o_start_det, o_stop_det, o_rd_addr}, 12'h000);
      rst = 1'b0;
      stop_cond();

      // Randomized transactions against a transaction-level model.
      for (int i = 0; i < 256; i++) mregs[i] = 8'(i) ^ 8'h7C;
      m_rd_addr = 8'h00;
      for (int t = 0; t < 28; t++) begin
         logic [7:0] id, sub, dat, e_rdata;
         logic [3:0] e_acks;
         logic       match;
         int         nwr, e_wr, r;
         r   = $urandom_range(0, 9);
         id  = (r < 4) ? 8'h42 : (r < 7) ? 8'h43 : 8'($urandom);
         sub = 8'($urandom);
         dat = 8'($urandom);
         nwr = $urandom_range(0, 3);
         match   = (id[7:1] == 7'h21);
         e_acks  = 4'b0000;
         e_wr    = 0;
         e_rdata = 8'hFF;
         if (match && id[0]) begin
            e_acks  = 4'b0001;
            e_rdata = mregs[m_rd_addr];
         end else if (match) begin
            e_acks = (nwr >= 2) ? 4'b0111 : (nwr == 1) ? 4'b0011 : 4'b0001;
            if (nwr >= 1) m_rd_addr = sub;
            if (nwr >= 2) begin
               e_wr       = 1;
               mregs[sub] = dat;
            end
         end
         run_check($sformatf("rnd%0d", t), id, sub, dat, nwr, e_acks, e_wr, sub, dat,
                   e_rdata, m_rd_addr, match);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #950000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
